instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming RV32I instruction encoder and program loader, the write-side counterpart to the core's instruction decoder. It accepts decoded instruction fields over a valid/ready handshake, packs each into a 32-bit machine word with immediate range checking, and writes the words to consecutive instruction-memory addresses. It sits between the test/boot loader and the instruction memory write port.

## Interface
- `ADDR_W`, 10: word-address width of the instruction memory.
- `BASE_ADDR`, 0: first word address written after `start_i`.

- `clk_i`  in  1  clock; all state is updated on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `start_i`  in  1  begins a load session; resets the pointer, count and errors.
- `in_valid_i`  in  1  field bundle valid.
- `in_ready_o`  out  1  encoder accepts the bundle this cycle.
- `fmt_i`  in  3  `instr_fmt_e` value: R, I, S, B, U or J.
- `op_i`  in  7  opcode, placed verbatim in bits [6:0].
- `rd_i`, `rs1_i`, `rs2_i`  in  5 each  register indices.
- `funct3_i`  in  3  funct3 field.
- `funct7_i`  in  7  funct7 field.
- `imm_i`  in  32  full signed immediate value; the U-format value is used unshifted.
- `last_i`  in  1  marks the final bundle of the session.
- `wr_en_o`  out  1  instruction-memory write strobe.
- `wr_addr_o`  out  ADDR_W  word address for the write.
- `wr_data_o`  out  32  encoded instruction.
- `count_o`  out  ADDR_W+1  number of words written this session.
- `done_o`  out  1  session finished.
- `err_o`  out  1  sticky error: immediate range error or illegal `fmt_i`.
- `ovf_o`  out  1  sticky: memory end was reached before `last_i`.

## Operation
- The FSM has three states: IDLE, STREAM and DONE.
- **Transitions**
  - From any state, `start_i` moves the FSM to STREAM. The pointer is loaded with `BASE_ADDR`, and `count_o`, `err_o`, `ovf_o` and `done_o` are cleared.
  - `in_ready_o` = (state == STREAM) && !`start_i`. A bundle offered in the same cycle as `start_i` is not accepted.
  - STREAM to DONE: an accepted bundle with `last_i`=1, or an accepted bundle written to address 2^ADDR_W−1. In the second case `ovf_o` is set if `last_i`=0.
- **Encoding**
  - R: {funct7, rs2, rs1, funct3, rd, op}
  - I: {imm[11:0], rs1, funct3, rd, op}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
- **Range checks**: a failing check sets `err_o`; the truncated word is still written.
  - I and S: imm[31:11] all equal.
  - B: imm[31:12] all equal, and imm[0]=0.
  - J: imm[31:20] all equal, and imm[0]=0.
  - U: imm[11:0]=0.
- **Illegal `fmt_i`**: writes `NOP_INSTR` (32'h00000013) and sets `err_o`.
- Pointer wrap is impossible: the FSM stops at the top address.
- `count_o` increments once per write and saturates at 2^ADDR_W.

## Timing
- **Reset values**: state IDLE; `in_ready_o` 0; `wr_en_o` 0; `wr_addr_o` `BASE_ADDR`; `wr_data_o` 0; `count_o` 0; `done_o` 0; `err_o` 0; `ovf_o` 0.
- **Write latency**: a bundle accepted in cycle N produces `wr_en_o`=1 in cycle N+1, with the registered address and data. `wr_en_o` is a single-cycle pulse per accepted bundle.
- **Throughput**: one bundle per cycle. There is no backpressure from memory, which is assumed always writable.
- `done_o` and `ovf_o` rise in the same cycle as the final `wr_en_o` pulse.
- `err_o` rises in the same cycle as the `wr_en_o` pulse of the offending word.
- **Back-to-back accepts**: addresses increment by 1 per cycle.
- **`start_i` while a write is pending**: the pending write, registered last cycle, still completes this cycle. The new session begins the following cycle.
- **Reset mid-session**: the pending write is dropped, and all outputs return to their reset values on the next edge.

## Structure
- **Add to `riscv_pkg`**:
  - `instr_fmt_e`: 3-bit enum with R=0, I=1, S=2, B=3, U=4, J=5; values 6 and 7 are illegal.
  - `NOP_INSTR` constant.
  - The FSM state enum.
- **Sub-module**: `instr_pack`, a combinational block that takes the fields and `fmt_i` and returns the 32-bit word plus a range-error flag. `instr_encoder` instantiates it and owns the FSM, registers and counters.

## Test plan
- **addi x1,x0,5**: `start_i`, then I-format bundle (op 0x13, rd 1, rs1 0, imm 5, `last_i` 0) → `wr_en_o` at N+1, addr 0, data 0x00500093.
- **Mixed stream**: R add x3,x1,x2 / S sw x2,4(x1) / B beq x1,x2,+8 / J jal x1,+16 / U lui x5,0x12345000 (last) → data 0x002081B3, 0x0020A223, 0x00208463, 0x010000EF, 0x123452B7 at addr 0–4. Then `count_o`=5, `done_o`=1, `err_o`=0.
- **Range errors**: I imm 2048 → `err_o`=1, word still written. Separately, B imm 7 (odd) → `err_o`=1.
- **Illegal format**: `fmt_i`=7 → writes 0x00000013, `err_o`=1.
- **Overflow**: `ADDR_W`=2, five bundles with no `last_i` → four writes at addr 0–3, then `done_o`=1 and `ovf_o`=1. The fifth bundle is not accepted (`in_ready_o`=0).
- **Restart and reset**: `start_i` asserted together with `in_valid_i` → that bundle is not accepted, the pointer returns to `BASE_ADDR`, and errors clear. `rst_i` asserted mid-stream → all outputs take their reset values next cycle, with no write.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I types and constants for the instruction encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Values 6 and 7 are deliberately left unnamed: they are illegal formats.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_fmt_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } enc_state_e;

    // True when value[31:lsb] are all copies of the sign bit.
    function automatic logic upper_bits_equal(input logic [31:0] value,
                                              input int unsigned lsb);
        logic [31:0] shifted;
        shifted = $signed(value) >>> lsb;
        return (shifted == 32'h0000_0000) || (shifted == 32'hFFFF_FFFF);
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
// Module      : instr_pack
// Description : Combinational RV32I field packer with immediate range check.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_pack
    import riscv_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_op,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_range_err,
    output logic        o_fmt_err
);

    always_comb begin
        o_word      = NOP_INSTR;
        o_range_err = 1'b0;
        o_fmt_err   = 1'b0;
        case (instr_fmt_e'(i_fmt))
            FMT_R: begin
                o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_op};
            end
            FMT_I: begin
                o_word      = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_op};
                o_range_err = !upper_bits_equal(i_imm, 11);
            end
            FMT_S: begin
                o_word      = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_op};
                o_range_err = !upper_bits_equal(i_imm, 11);
            end
            FMT_B: begin
                o_word      = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                               i_imm[4:1], i_imm[11], i_op};
                o_range_err = !upper_bits_equal(i_imm, 12) || i_imm[0];
            end
            FMT_U: begin
                // The immediate arrives already positioned in bits [31:12].
                o_word      = {i_imm[31:12], i_rd, i_op};
                o_range_err = (i_imm[11:0] != 12'd0);
            end
            FMT_J: begin
                o_word      = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_op};
                o_range_err = !upper_bits_equal(i_imm, 20) || i_imm[0];
            end
            default: begin
                o_word    = NOP_INSTR;
                o_fmt_err = 1'b1;
            end
        endcase
    end

endmodule : instr_pack
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Streams encoded RV32I words into consecutive imem addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        fmt_i,
    input  logic [6:0]        op_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    input  logic              last_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              done_o,
    output logic              err_o,
    output logic              ovf_o
);

    localparam logic [ADDR_W-1:0] c_BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_TOP_ADDR  = '1;
    localparam logic [ADDR_W:0]   c_COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    enc_state_e        r_state;
    enc_state_e        w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic [ADDR_W:0]   r_count;
    logic              r_done;
    logic              r_err;
    logic              r_ovf;

    logic              w_ready;
    logic              w_accept;
    logic              w_at_top;
    logic [31:0]       w_word;
    logic              w_range_err;
    logic              w_fmt_err;

    instr_pack u_pack (
        .i_fmt       (fmt_i),
        .i_op        (op_i),
        .i_rd        (rd_i),
        .i_rs1       (rs1_i),
        .i_rs2       (rs2_i),
        .i_funct3    (funct3_i),
        .i_funct7    (funct7_i),
        .i_imm       (imm_i),
        .o_word      (w_word),
        .o_range_err (w_range_err),
        .o_fmt_err   (w_fmt_err)
    );

    assign w_accept = in_valid_i && w_ready;
    assign w_at_top = (r_ptr == c_TOP_ADDR);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (start_i) begin
            w_state_next = ST_STREAM;
        end else begin
            case (r_state)
                ST_STREAM: begin
                    if (w_accept && (last_i || w_at_top)) begin
                        w_state_next = ST_DONE;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    // Output logic: a bundle offered alongside start belongs to no session.
    always_comb begin
        w_ready = (r_state == ST_STREAM) && !start_i;
    end

    // Write pipeline, pointer and session status
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr     <= c_BASE;
            r_wr_en   <= 1'b0;
            r_wr_addr <= c_BASE;
            r_wr_data <= 32'd0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            if (start_i) begin
                r_ptr   <= c_BASE;
                r_count <= '0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (w_accept) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_word;
                if (!w_at_top) begin
                    r_ptr <= r_ptr + 1'b1;
                end
                if (r_count != c_COUNT_MAX) begin
                    r_count <= r_count + 1'b1;
                end
                r_err <= r_err | w_range_err | w_fmt_err;
                if (last_i || w_at_top) begin
                    r_done <= 1'b1;
                end
                // Running out of memory without a terminating bundle.
                if (w_at_top && !last_i) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign in_ready_o = w_ready;
    assign wr_en_o    = r_wr_en;
    assign wr_addr_o  = r_wr_addr;
    assign wr_data_o  = r_wr_data;
    assign count_o    = r_count;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign ovf_o      = r_ovf;

endmodule : instr_encoder
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed vector bench for instr_encoder (10-bit and 2-bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start2;
    logic        in_valid;
    logic        in_valid2;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        last;

    logic        in_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [10:0] count;
    logic        done;
    logic        err;
    logic        ovf;

    logic        in_ready_s;
    logic        wr_en_s;
    logic [1:0]  wr_addr_s;
    logic [31:0] wr_data_s;
    logic [2:0]  count_s;
    logic        done_s;
    logic        err_s;
    logic        ovf_s;

    int n_pass;
    int n_total;

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .fmt_i(fmt), .op_i(op), .rd_i(rd), .rs1_i(rs1),
        .rs2_i(rs2), .funct3_i(funct3), .funct7_i(funct7), .imm_i(imm),
        .last_i(last), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .count_o(count), .done_o(done), .err_o(err), .ovf_o(ovf)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .in_valid_i(in_valid2),
        .in_ready_o(in_ready_s), .fmt_i(fmt), .op_i(op), .rd_i(rd), .rs1_i(rs1),
        .rs2_i(rs2), .funct3_i(funct3), .funct7_i(funct7), .imm_i(imm),
        .last_i(last), .wr_en_o(wr_en_s), .wr_addr_o(wr_addr_s), .wr_data_o(wr_data_s),
        .count_o(count_s), .done_o(done_s), .err_o(err_s), .ovf_o(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sess;
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        last;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        exp_done;
        logic [10:0] exp_count;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic sess, logic [2:0] f, logic [6:0] o, logic [4:0] d,
                                logic [4:0] s1, logic [4:0] s2, logic [2:0] f3,
                                logic [6:0] f7, logic [31:0] im, logic lst,
                                logic [31:0] ed, logic ee, logic edn, logic [10:0] ec);
        vec_t v;
        v.sess = sess; v.fmt = f; v.op = o; v.rd = d; v.rs1 = s1; v.rs2 = s2;
        v.f3 = f3; v.f7 = f7; v.imm = im; v.last = lst;
        v.exp_data = ed; v.exp_err = ee; v.exp_done = edn; v.exp_count = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply(input vec_t v);
        fmt = v.fmt; op = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm; last = v.last;
    endtask

    initial begin
        vec_t addi_v;
        vec_t bad_v;
        logic [9:0] exp_addr;

        n_pass = 0; n_total = 0;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
        fmt = 3'd0; op = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0; last = 1'b0;

        //              sess fmt  op     rd  rs1 rs2 f3  f7  imm           last data          err  done cnt
        tbl[0]  = mk(1, 3'd1, 7'h13, 1, 0, 0, 0, 0, 32'd5,        0, 32'h0050_0093, 0, 0, 11'd1);
        tbl[1]  = mk(1, 3'd0, 7'h33, 3, 1, 2, 0, 0, 32'd0,        0, 32'h0020_81B3, 0, 0, 11'd1);
        tbl[2]  = mk(0, 3'd2, 7'h23, 0, 1, 2, 2, 0, 32'd4,        0, 32'h0020_A223, 0, 0, 11'd2);
        tbl[3]  = mk(0, 3'd3, 7'h63, 0, 1, 2, 0, 0, 32'd8,        0, 32'h0020_8463, 0, 0, 11'd3);
        tbl[4]  = mk(0, 3'd5, 7'h6F, 1, 0, 0, 0, 0, 32'd16,       0, 32'h0100_00EF, 0, 0, 11'd4);
        tbl[5]  = mk(0, 3'd4, 7'h37, 5, 0, 0, 0, 0, 32'h1234_5000, 1, 32'h1234_52B7, 0, 1, 11'd5);
        tbl[6]  = mk(1, 3'd1, 7'h13, 1, 0, 0, 0, 0, 32'd2048,     0, 32'h8000_0093, 1, 0, 11'd1);
        tbl[7]  = mk(0, 3'd1, 7'h13, 1, 0, 0, 0, 0, 32'd1,        0, 32'h0010_0093, 1, 0, 11'd2);
        tbl[8]  = mk(1, 3'd3, 7'h63, 0, 1, 2, 0, 0, 32'd7,        0, 32'h0020_8363, 1, 0, 11'd1);
        tbl[9]  = mk(1, 3'd7, 7'h33, 3, 1, 2, 0, 0, 32'd0,        1, 32'h0000_0013, 1, 1, 11'd1);
        tbl[10] = mk(1, 3'd1, 7'h13, 1, 0, 0, 0, 0, 32'hFFFF_F800, 0, 32'h8000_0093, 0, 0, 11'd1);
        tbl[11] = mk(0, 3'd4, 7'h37, 5, 0, 0, 0, 0, 32'h0000_0800, 1, 32'h0000_02B7, 1, 1, 11'd2);

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst wr_en",    {31'd0, wr_en},    32'd0);
        chk("rst wr_addr",  {22'd0, wr_addr},  32'd0);
        chk("rst wr_data",  wr_data,           32'd0);
        chk("rst count",    {21'd0, count},    32'd0);
        chk("rst done",     {31'd0, done},     32'd0);
        chk("rst err",      {31'd0, err},      32'd0);
        chk("rst ovf",      {31'd0, ovf},      32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table: consecutive non-session records are sent back-to-back
        exp_addr = 10'd0;
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].sess) begin
                in_valid = 1'b0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                exp_addr = 10'd0;
            end
            apply(tbl[i]);
            in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d wr_en", i),   {31'd0, wr_en},   32'd1);
            chk($sformatf("v%0d wr_addr", i), {22'd0, wr_addr}, {22'd0, exp_addr});
            chk($sformatf("v%0d wr_data", i), wr_data,          tbl[i].exp_data);
            chk($sformatf("v%0d err", i),     {31'd0, err},     {31'd0, tbl[i].exp_err});
            chk($sformatf("v%0d done", i),    {31'd0, done},    {31'd0, tbl[i].exp_done});
            chk($sformatf("v%0d count", i),   {21'd0, count},   {21'd0, tbl[i].exp_count});
            chk($sformatf("v%0d ovf", i),     {31'd0, ovf},     32'd0);
            exp_addr = exp_addr + 10'd1;
        end
        @(negedge clk);
        chk("after last wr_en", {31'd0, wr_en}, 32'd0);

        // Restart while a write is pending, with a bundle offered alongside start
        addi_v = tbl[0];
        bad_v  = tbl[9];
        bad_v.last = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        apply(bad_v);
        in_valid = 1'b1;
        @(negedge clk);
        apply(addi_v);
        @(negedge clk);
        chk("rs pending wr_en",   {31'd0, wr_en},   32'd1);
        chk("rs pending wr_addr", {22'd0, wr_addr}, 32'd1);
        chk("rs pending err",     {31'd0, err},     32'd1);
        start = 1'b1;
        #1;
        chk("rs start in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        chk("rs wr_en",  {31'd0, wr_en},  32'd0);
        chk("rs err",    {31'd0, err},    32'd0);
        chk("rs count",  {21'd0, count},  32'd0);
        chk("rs done",   {31'd0, done},   32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rs new wr_addr", {22'd0, wr_addr}, 32'd0);
        chk("rs new wr_data", wr_data,          32'h0050_0093);
        chk("rs new count",   {21'd0, count},   32'd1);

        // Reset mid-stream drops the pending bundle
        apply(bad_v);
        in_valid = 1'b1;
        @(negedge clk);
        chk("mid err before rst", {31'd0, err}, 32'd1);
        apply(addi_v);
        rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid rst wr_en",    {31'd0, wr_en},    32'd0);
        chk("mid rst wr_addr",  {22'd0, wr_addr},  32'd0);
        chk("mid rst wr_data",  wr_data,           32'd0);
        chk("mid rst count",    {21'd0, count},    32'd0);
        chk("mid rst err",      {31'd0, err},      32'd0);
        chk("mid rst done",     {31'd0, done},     32'd0);
        chk("mid rst in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Overflow on the 4-word instance: five bundles, no last
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        apply(addi_v);
        in_valid2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            imm = 32'(k);
            #1;
            chk($sformatf("ovf b%0d in_ready", k), {31'd0, in_ready_s}, 32'd1);
            @(negedge clk);
            chk($sformatf("ovf b%0d wr_en", k),   {31'd0, wr_en_s},   32'd1);
            chk($sformatf("ovf b%0d wr_addr", k), {30'd0, wr_addr_s}, 32'(k));
            chk($sformatf("ovf b%0d count", k),   {29'd0, count_s},   32'(k + 1));
            chk($sformatf("ovf b%0d done", k),    {31'd0, done_s},    {31'd0, (k == 3)});
            chk($sformatf("ovf b%0d ovf", k),     {31'd0, ovf_s},     {31'd0, (k == 3)});
        end
        #1;
        chk("ovf b4 in_ready", {31'd0, in_ready_s}, 32'd0);
        @(negedge clk);
        in_valid2 = 1'b0;
        chk("ovf b4 wr_en", {31'd0, wr_en_s}, 32'd0);
        chk("ovf b4 count", {29'd0, count_s}, 32'd4);
        chk("ovf b4 ovf",   {31'd0, ovf_s},   32'd1);
        chk("ovf b4 err",   {31'd0, err_s},   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_instr_encoder
`default_nettype wire
